// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch address generator with stall, branch/flush redirect and one pending redirect.
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                STEP       = 4,
  parameter int                ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              pend_valid,
  output logic              misalign
);
  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);
  logic [ADDR_W-1:0] pc_q, pc_d, pend_target_q, pend_target_d;
  logic ce_q, ce_d, pend_valid_q, pend_valid_d;
  always_comb begin
    ce_d = 1'b1;
    pc_d = pc_q;
    pend_valid_d = pend_valid_q;
    pend_target_d = pend_target_q;
    if (rst) begin
      ce_d = 1'b0;
      pc_d = RESET_VEC;
      pend_valid_d = 1'b0;
      pend_target_d = '0;
    end else if (!ce_q) begin
      pc_d = pc_q;
    end else if (flush) begin
      pc_d = flush_pc;
      pend_valid_d = 1'b0;
    end else if (stall) begin
      // a newer branch under stall replaces any older pending one
      pend_valid_d = branch_flag | pend_valid_q;
      pend_target_d = branch_flag ? branch_target : pend_target_q;
    end else if (branch_flag) begin
      pc_d = branch_target;
      pend_valid_d = 1'b0;
    end else if (pend_valid_q) begin
      pc_d = pend_target_q;
      pend_valid_d = 1'b0;
    end else begin
      pc_d = pc_q + STEP_W;
    end
  end
  always_ff @(posedge clk) begin
    ce_q <= ce_d;
    pc_q <= pc_d;
    pend_valid_q <= pend_valid_d;
    pend_target_q <= pend_target_d;
  end
  assign pc = pc_q;
  assign ce = ce_q;
  assign pend_valid = pend_valid_q;
  generate
    if (ALIGN_BITS == 0) begin : g_noalign
      assign misalign = 1'b0;
    end else begin : g_align
      assign misalign = |pc_q[ALIGN_BITS-1:0];
    end
  endgenerate
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen (32-bit default and 8-bit wrap instance).
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst, stall, branch_flag, flush, rst8;
  logic [31:0] branch_target, flush_pc, pc;
  logic ce, pend_valid, misalign;
  logic [7:0] pc8;
  logic ce8, pend_valid8, misalign8;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        w8;
    logic [31:0] pc;
    logic        ce;
    logic        pv;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .flush(flush), .flush_pc(flush_pc),
    .pc(pc), .ce(ce), .pend_valid(pend_valid), .misalign(misalign)
  );

  pc_gen #(.ADDR_W(8), .RESET_VEC(8'hF8), .STEP(4), .ALIGN_BITS(2)) dut8 (
    .clk(clk), .rst(rst8), .stall(1'b0), .branch_flag(1'b0),
    .branch_target(8'h00), .flush(1'b0), .flush_pc(8'h00),
    .pc(pc8), .ce(ce8), .pend_valid(pend_valid8), .misalign(misalign8)
  );

  task automatic cmp(input string tag, input string field, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, got, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    cmp(e.tag, "pc", e.w8 ? {24'h0, pc8} : pc, e.pc);
    cmp(e.tag, "ce", {31'h0, e.w8 ? ce8 : ce}, {31'h0, e.ce});
    cmp(e.tag, "pend_valid", {31'h0, e.w8 ? pend_valid8 : pend_valid}, {31'h0, e.pv});
    cmp(e.tag, "misalign", {31'h0, e.w8 ? misalign8 : misalign}, {31'h0, e.mis});
  endtask

  task automatic cyc(input string tag, input logic r, input logic s, input logic b,
                     input logic [31:0] bt, input logic f, input logic [31:0] fp,
                     input logic [31:0] epc, input logic ece, input logic epv, input logic emis);
    rst = r; stall = s; branch_flag = b; branch_target = bt; flush = f; flush_pc = fp;
    sb.push_back('{tag, 1'b0, epc, ece, epv, emis});
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic cyc8(input string tag, input logic r, input logic [31:0] epc, input logic ece);
    rst8 = r;
    sb.push_back('{tag, 1'b1, epc, ece, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    rst8 = 1'b1;
    // reset and start-up
    cyc("rst0", 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    cyc("rst1", 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    cyc("rst2", 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    cyc("start", 0, 1, 1, 32'h900, 1, 32'h1234, 32'h0, 1, 0, 0);
    cyc("seq4", 0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);
    cyc("seq8", 0, 0, 0, 0, 0, 0, 32'h8, 1, 0, 0);
    cyc("seqC", 0, 0, 0, 0, 0, 0, 32'hC, 1, 0, 0);
    cyc("seq10", 0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0);
    // branch while running
    cyc("br100", 0, 0, 1, 32'h100, 0, 0, 32'h100, 1, 0, 0);
    cyc("seq104", 0, 0, 0, 0, 0, 0, 32'h104, 1, 0, 0);
    // branch during stall, newer overwrites older
    cyc("st1", 0, 1, 0, 0, 0, 0, 32'h104, 1, 0, 0);
    cyc("st2", 0, 1, 1, 32'h200, 0, 0, 32'h104, 1, 1, 0);
    cyc("st3", 0, 1, 1, 32'h300, 0, 0, 32'h104, 1, 1, 0);
    cyc("st4", 0, 1, 0, 0, 0, 0, 32'h104, 1, 1, 0);
    cyc("pend300", 0, 0, 0, 0, 0, 0, 32'h300, 1, 0, 0);
    cyc("seq304", 0, 0, 0, 0, 0, 0, 32'h304, 1, 0, 0);
    // flush beats stall, branch and pending
    cyc("pend500", 0, 1, 1, 32'h500, 0, 0, 32'h304, 1, 1, 0);
    cyc("flush", 0, 1, 1, 32'h400, 1, 32'h8000_0180, 32'h8000_0180, 1, 0, 0);
    cyc("post_fl", 0, 0, 0, 0, 0, 0, 32'h8000_0184, 1, 0, 0);
    // live branch beats stale pending
    cyc("pend600", 0, 1, 1, 32'h600, 0, 0, 32'h8000_0184, 1, 1, 0);
    cyc("live700", 0, 0, 1, 32'h700, 0, 0, 32'h700, 1, 0, 0);
    cyc("seq704", 0, 0, 0, 0, 0, 0, 32'h704, 1, 0, 0);
    // misalign, then reset with a pending redirect
    cyc("mis102", 0, 0, 1, 32'h102, 0, 0, 32'h102, 1, 0, 1);
    cyc("mis106", 0, 0, 0, 0, 0, 0, 32'h106, 1, 0, 1);
    cyc("pend900", 0, 1, 1, 32'h900, 0, 0, 32'h106, 1, 1, 1);
    cyc("rst_pend", 1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    cyc("restart", 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    cyc("no_pend", 0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);
    // 8-bit wrap instance
    cyc8("w_rst", 1, 32'hF8, 0);
    cyc8("w_start", 0, 32'hF8, 1);
    cyc8("w_FC", 0, 32'hFC, 1);
    cyc8("w_00", 0, 32'h00, 1);
    cyc8("w_04", 0, 32'h04, 1);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
